rc4_keystream: RTL and testbench

RC4_KEYSTREAM -- requirements
Module: rc4_keystream

---
 rtl/rc4_keystream_if.sv | 23 ++
 rtl/rc4_keystream.sv | 128 ++++++++++++
 tb/tb_rc4_keystream.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_if.sv
// Handshake bundle for the RC4 keystream block: key byte input,
// keystream byte output, restart pulse and busy flag.
interface rc4_keystream_if;
   logic [7:0] key_in;
   logic       key_last;
   logic       key_rvalid;
   logic       key_rready;
   logic       rekey;
   logic [7:0] ks_out;
   logic       ks_wvalid;
   logic       ks_wready;
   logic       busy;

   modport master (
      output key_in, key_last, key_rvalid, rekey, ks_wready,
      input  key_rready, ks_out, ks_wvalid, busy
   );

   modport slave (
      input  key_in, key_last, key_rvalid, rekey, ks_wready,
      output key_rready, ks_out, ks_wvalid, busy
   );
endinterface

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: key load, one-cycle S init, 256-cycle KSA,
// then one PRGA byte per cycle behind a registered valid/ready output.
module rc4_keystream #(
   parameter int KEY_MAX = 16
) (
   input  logic           clk,
   input  logic           rst,
   rc4_keystream_if.slave bus
);
   localparam int LW = $clog2(KEY_MAX + 1);
   localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

   typedef enum logic [2:0] {
      IDLE, KEY_LOAD, S_INIT, KSA, GEN
   } state_t;

   state_t        state;
   logic [7:0]    s_mem [256];
   logic [7:0]    k_mem [2**KW];
   logic [LW-1:0] len;
   logic [KW-1:0] kidx;
   logic [7:0]    i, j;
   logic [7:0]    ks_q;
   logic          ks_v;

   logic       key_fire, gen_en, s_we;
   logic [7:0] i_g, j_g, j_k, si, sj, t, ks_val;
   logic [7:0] a_idx, b_idx, a_val, b_val;

   assign bus.key_rready = (state == IDLE) | (state == KEY_LOAD);
   assign bus.busy       = (state != IDLE);
   assign bus.ks_out     = ks_q;
   assign bus.ks_wvalid  = ks_v;

   always_comb begin
      i_g = i + 8'd1;
      si  = s_mem[i_g];
      j_g = j + si;
      sj  = s_mem[j_g];
      t   = si + sj;
      // output read must see the swap that happens on this same edge
      if (t == i_g)      ks_val = sj;
      else if (t == j_g) ks_val = si;
      else               ks_val = s_mem[t];
      j_k = j + s_mem[i] + k_mem[kidx];
      key_fire = bus.key_rvalid & bus.key_rready & ~bus.rekey;
      gen_en   = (state == GEN) & (~ks_v | bus.ks_wready) & ~bus.rekey;
      s_we     = gen_en | ((state == KSA) & ~bus.rekey);
      if (state == KSA) begin
         a_idx = i;
         b_idx = j_k;
         a_val = s_mem[j_k];
         b_val = s_mem[i];
      end else begin
         a_idx = i_g;
         b_idx = j_g;
         a_val = sj;
         b_val = si;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ks_v  <= 1'b0;
         ks_q  <= 8'h00;
         len   <= '0;
         kidx  <= '0;
         i     <= 8'h00;
         j     <= 8'h00;
      end else if (bus.rekey) begin
         state <= IDLE;
         ks_v  <= 1'b0;
         len   <= '0;
         kidx  <= '0;
         i     <= 8'h00;
         j     <= 8'h00;
      end else begin
         unique case (state)
            IDLE: if (key_fire) begin
               len   <= LW'(1);
               state <= (bus.key_last || KEY_MAX == 1) ? S_INIT : KEY_LOAD;
            end
            KEY_LOAD: if (key_fire) begin
               len <= len + LW'(1);
               if (bus.key_last || len == LW'(KEY_MAX - 1))
                  state <= S_INIT;
            end
            S_INIT: begin
               i     <= 8'h00;
               j     <= 8'h00;
               kidx  <= '0;
               state <= KSA;
            end
            KSA: begin
               i    <= i + 8'd1;
               j    <= j_k;
               kidx <= (LW'(kidx) == len - LW'(1)) ? '0 : kidx + KW'(1);
               if (i == 8'hFF) begin
                  i     <= 8'h00;
                  j     <= 8'h00;
                  state <= GEN;
               end
            end
            GEN: if (gen_en) begin
               i    <= i_g;
               j    <= j_g;
               ks_q <= ks_val;
               ks_v <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // S and K hold no reset: S is rebuilt in S_INIT before any use
   always_ff @(posedge clk) begin
      if (key_fire)
         k_mem[len[KW-1:0]] <= bus.key_in;
      if (state == S_INIT) begin
         for (int n = 0; n < 256; n++)
            s_mem[n] <= 8'(n);
      end else if (s_we) begin
         s_mem[a_idx] <= a_val;
         s_mem[b_idx] <= b_val;
      end
   end
endmodule

// File: tb/tb_rc4_keystream.sv
// Bench for rc4_keystream: RC4 reference model, literal vectors,
// latency, stall, KEY_MAX truncation, rekey and async reset checks.
module tb_rc4_keystream;
   logic clk;
   logic rst;

   rc4_keystream_if bus0();
   rc4_keystream_if bus1();

   rc4_keystream #(.KEY_MAX(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   rc4_keystream #(.KEY_MAX(3))  u1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp0_q[$];
   logic [7:0] exp1_q[$];
   logic [7:0] mq[$];

   logic [7:0] lit_key[10];
   logic [7:0] lit_wiki[6];
   logic [7:0] lit_sec[8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   function automatic void rc4_model(input logic [7:0] key[$], input int n);
      logic [7:0] s[256];
      logic [7:0] tmp;
      int x, y;
      mq = {};
      for (int m = 0; m < 256; m++) s[m] = 8'(m);
      y = 0;
      for (x = 0; x < 256; x++) begin
         y = (y + s[x] + key[x % key.size()]) % 256;
         tmp = s[x]; s[x] = s[y]; s[y] = tmp;
      end
      x = 0;
      y = 0;
      for (int m = 0; m < n; m++) begin
         x = (x + 1) % 256;
         y = (y + s[x]) % 256;
         tmp = s[x]; s[x] = s[y]; s[y] = tmp;
         mq.push_back(s[(int'(s[x]) + int'(s[y])) % 256]);
      end
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d,
                        input logic l);
      if (sel == 0) begin
         bus0.key_rvalid = v; bus0.key_in = d; bus0.key_last = l;
      end else begin
         bus1.key_rvalid = v; bus1.key_in = d; bus1.key_last = l;
      end
   endtask

   function automatic logic rready(input int sel);
      return (sel == 0) ? bus0.key_rready : bus1.key_rready;
   endfunction

   // returns at posedge+1 after the last accepted byte (or timeout)
   task automatic send_key(input int sel, input logic [7:0] k[$],
                           input logic use_last, output int acc);
      logic r, got;
      acc = 0;
      for (int n = 0; n < k.size(); n++) begin
         drive(sel, 1'b1, k[n], use_last && (n == k.size() - 1));
         got = 1'b0;
         for (int w = 0; w < 4 && !got; w++) begin
            @(negedge clk);
            r = rready(sel);
            @(posedge clk);
            #1;
            if (r) begin
               got = 1'b1;
               acc++;
            end
         end
         if (!got) break;
      end
      drive(sel, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic pulse_rekey();
      bus0.rekey = 1'b1;
      @(posedge clk);
      #1;
      bus0.rekey = 1'b0;
   endtask

   task automatic drain(input int sel, input string name);
      int w = 0;
      while (((sel == 0) ? exp0_q.size() : exp1_q.size()) > 0 && w < 2000) begin
         @(posedge clk);
         #1;
         if (sel == 0 && bus0.ks_wready !== 1'b1 && w > 0)
            bus0.ks_wready = 1'($urandom_range(0, 1));
         w++;
      end
      chk(name, (sel == 0) ? exp0_q.size() : exp1_q.size(), 0);
      bus0.ks_wready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input logic [7:0] lit[], input int n);
      for (int m = 0; m < n; m++)
         chk($sformatf("%s[%0d]", name, m), mq[m], lit[m]);
   endtask

   // single compare process for both DUTs
   logic       stalled = 1'b0;
   logic [7:0] prev_out = 8'h00;
   always @(negedge clk) begin
      if (!rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled)
            chk("stall_hold", {23'd0, bus0.ks_wvalid, bus0.ks_out},
                {23'd0, 1'b1, prev_out});
         if (bus0.ks_wvalid && exp0_q.size() > 0) begin
            chk("ks0", bus0.ks_out, exp0_q[0]);
            if (bus0.ks_wready) void'(exp0_q.pop_front());
         end
         if (bus1.ks_wvalid && exp1_q.size() > 0) begin
            chk("ks1", bus1.ks_out, exp1_q[0]);
            if (bus1.ks_wready) void'(exp1_q.pop_front());
         end
         stalled  = bus0.ks_wvalid && !bus0.ks_wready && !bus0.rekey;
         prev_out = bus0.ks_out;
      end
   end

   initial begin
      logic [7:0] k_key[$];
      logic [7:0] k_wiki[$];
      logic [7:0] k_sec[$];
      logic [7:0] k_long[$];
      int acc;
      int lat;

      lit_key  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                   8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
      lit_wiki = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
      lit_sec  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
      k_key  = {8'h4B, 8'h65, 8'h79};
      k_wiki = {8'h57, 8'h69, 8'h6B, 8'h69};
      k_sec  = {8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
      k_long = {8'h4B, 8'h65, 8'h79, 8'h2E, 8'h2E};

      rst = 1'b0;
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      bus0.rekey = 1'b0; bus1.rekey = 1'b0;
      bus0.ks_wready = 1'b1; bus1.ks_wready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rready", bus0.key_rready, 1);
      chk("rst_busy", bus0.busy, 0);
      chk("rst_wvalid", bus0.ks_wvalid, 0);
      chk("rst_ksout", bus0.ks_out, 0);
      chk("rst_rready1", bus1.key_rready, 1);
      chk("rst_busy1", bus1.busy, 0);
      rst = 1'b1;

      // "Key", full-rate output, latency measured from last key edge
      rc4_model(k_key, 10);
      pin("model_key", lit_key, 10);
      exp0_q = mq;
      send_key(0, k_key, 1'b1, acc);
      chk("key_acc", acc, 3);
      chk("busy_run", bus0.busy, 1);
      chk("rready_run", bus0.key_rready, 0);
      lat = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         #1;
         if (bus0.ks_wvalid) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, 258);
      drain(0, "drain_key");
      pulse_rekey();
      chk("rekey_busy", bus0.busy, 0);
      chk("rekey_wvalid", bus0.ks_wvalid, 0);

      // "Wiki"
      rc4_model(k_wiki, 6);
      pin("model_wiki", lit_wiki, 6);
      exp0_q = mq;
      send_key(0, k_wiki, 1'b1, acc);
      chk("wiki_acc", acc, 4);
      drain(0, "drain_wiki");
      pulse_rekey();

      // "Secret" with random backpressure
      rc4_model(k_sec, 8);
      pin("model_sec", lit_sec, 8);
      exp0_q = mq;
      bus0.ks_wready = 1'b0;
      send_key(0, k_sec, 1'b1, acc);
      chk("sec_acc", acc, 6);
      drain(0, "drain_sec");
      pulse_rekey();

      // KEY_MAX=3 truncation on the second instance
      rc4_model(k_key, 3);
      exp1_q = mq;
      send_key(1, k_long, 1'b0, acc);
      chk("trunc_acc", acc, 3);
      chk("trunc_rready", bus1.key_rready, 0);
      drain(1, "drain_trunc");

      // rekey in the middle of KSA, then reload
      send_key(0, k_wiki, 1'b1, acc);
      repeat (50) @(posedge clk);
      #1;
      chk("ksa_busy", bus0.busy, 1);
      pulse_rekey();
      chk("abort_busy", bus0.busy, 0);
      chk("abort_rready", bus0.key_rready, 1);
      chk("abort_wvalid", bus0.ks_wvalid, 0);
      rc4_model(k_wiki, 3);
      exp0_q = mq;
      send_key(0, k_wiki, 1'b1, acc);
      drain(0, "drain_reload");
      pulse_rekey();

      // async reset while a byte is held
      rc4_model(k_key, 1);
      exp0_q = mq;
      bus0.ks_wready = 1'b0;
      send_key(0, k_key, 1'b1, acc);
      lat = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         #1;
         if (bus0.ks_wvalid) begin
            lat = k;
            break;
         end
      end
      chk("held_latency", lat, 258);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_wvalid", bus0.ks_wvalid, 0);
      chk("arst_busy", bus0.busy, 0);
      chk("arst_rready", bus0.key_rready, 1);
      chk("arst_ksout", bus0.ks_out, 0);
      exp0_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus0.ks_wready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_busy", bus0.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
